// File: rtl/spi_reg_frontend.sv
// spi_reg_frontend: SPI mode-0 target (MSB-first, 16-bit frames) feeding the
// PWM control register bank. SCLK/COPI/nCS are oversampled in the clk domain.
// Optional feature: define SPI_READBACK_EN to make 16-bit read frames valid and
// shift reg[addr] out on cipo; when undefined cipo is tied low and reads are
// dropped silently.
`timescale 1ns/1ps
module spi_reg_frontend #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_DUTY  = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       txn_done,
    output logic       txn_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic                   sclk_h, ncs_h;
    logic [SYNC_STAGES:0]   prime_pipe;
    logic                   armed;
    logic [15:0]            shreg;
    logic [4:0]             bitcnt;
    logic                   wr_en, done_d, err_d;

    wire sclk_s   = sclk_sync[SYNC_STAGES-1];
    wire copi_s   = copi_sync[SYNC_STAGES-1];
    wire ncs_s    = ncs_sync[SYNC_STAGES-1];
    wire sclk_rise = sclk_s & ~sclk_h;
    wire ncs_fall = ~ncs_s & ncs_h;
    wire ncs_rise = ncs_s & ~ncs_h;
    // The sync flops start from reset values, not real samples; only trust
    // synced ncs for arming once the chain and history flop have been refilled.
    wire primed   = prime_pipe[SYNC_STAGES];

    wire       is_write = shreg[15];
    wire [6:0] addr     = shreg[14:8];
    wire       len_ok   = (bitcnt == 5'd16);
    wire       addr_ok  = (addr <= 7'd4);

    // Input synchronisers plus history flops for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_h    <= 1'b0;
            ncs_h     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_h    <= sclk_s;
            ncs_h     <= ncs_s;
        end
    end

    // Arm only after nCS has been seen idle-high, so a frame in flight at reset release is skipped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_pipe <= '0;
            armed      <= 1'b0;
        end else begin
            prime_pipe <= {prime_pipe[SYNC_STAGES-1:0], 1'b1};
            armed      <= armed | (primed & ncs_s);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ncs_fall && armed) state_nxt = SHIFT;
            SHIFT:   if (ncs_rise)          state_nxt = COMMIT;
            COMMIT:                         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // FSM outputs: commit decision, evaluated only in COMMIT
    always_comb begin
        wr_en  = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        if (state == COMMIT) begin
            if (len_ok && is_write && addr_ok) begin
                wr_en  = 1'b1;
                done_d = 1'b1;
            end else if (len_ok && !is_write) begin
`ifdef SPI_READBACK_EN
                done_d = 1'b1;
`endif
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Frame shifter; an SCLK rise coinciding with the nCS rise is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (state == IDLE && state_nxt == SHIFT) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (state == SHIFT && !ncs_rise && sclk_rise) begin
            shreg  <= {shreg[14:0], copi_s};
            bitcnt <= (bitcnt == 5'd17) ? 5'd17 : bitcnt + 5'd1;
        end
    end

    // Control register bank; only the addressed register is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= RESET_DUTY;
        end else if (wr_en) begin
            case (addr)
                7'd0:    en_reg_out_7_0  <= shreg[7:0];
                7'd1:    en_reg_out_15_8 <= shreg[7:0];
                7'd2:    en_reg_pwm_7_0  <= shreg[7:0];
                7'd3:    en_reg_pwm_15_8 <= shreg[7:0];
                7'd4:    pwm_duty_cycle  <= shreg[7:0];
                default: ;
            endcase
        end
    end

    // Transaction status pulses, aligned with the register load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_done <= 1'b0;
            txn_err  <= 1'b0;
        end else begin
            txn_done <= done_d;
            txn_err  <= err_d;
        end
    end

`ifdef SPI_READBACK_EN
    logic [7:0] rd_data;
    logic [7:0] tx_sr;
    wire        sclk_fall = ~sclk_s & sclk_h;

    // Read mux; after 8 rises shreg[6:0] holds the address field
    always_comb begin
        rd_data = 8'h00;
        case (shreg[6:0])
            7'd0:    rd_data = en_reg_out_7_0;
            7'd1:    rd_data = en_reg_out_15_8;
            7'd2:    rd_data = en_reg_pwm_7_0;
            7'd3:    rd_data = en_reg_pwm_15_8;
            7'd4:    rd_data = pwm_duty_cycle;
            default: rd_data = 8'h00;
        endcase
    end

    // Readback shifter: load on the fall after the 8th rise, then one bit per fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cipo  <= 1'b0;
            tx_sr <= 8'h00;
        end else if (ncs_s) begin
            cipo  <= 1'b0;
        end else if (state == SHIFT && sclk_fall) begin
            if (bitcnt == 5'd8) begin
                cipo  <= rd_data[7];
                tx_sr <= {rd_data[6:0], 1'b0};
            end else if (bitcnt > 5'd8) begin
                cipo  <= tx_sr[7];
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
        end
    end
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_frontend.sv
// Directed bench for spi_reg_frontend: clk 10 MHz, SCLK 100 kHz, mode 0.
`timescale 1ns/1ps
module tb_spi_reg_frontend;

    localparam logic [7:0] RDUTY = 8'h5A;
    localparam int         HALF  = 5000;   // SCLK half period in ns

    logic       clk, rst_n, sclk, copi, ncs;
    logic       cipo, txn_done, txn_err;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    wire [39:0] regs_all = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
                            en_reg_pwm_15_8, pwm_duty_cycle};

    spi_reg_frontend #(.SYNC_STAGES(2), .RESET_DUTY(RDUTY)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .txn_done(txn_done), .txn_err(txn_err)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (txn_done) done_cnt <= done_cnt + 1;
        if (txn_err)  err_cnt  <= err_cnt + 1;
    end

    task automatic spi_bits(input logic [31:0] val, input int n, output logic [15:0] cap);
        cap = '0;
        for (int i = n - 1; i >= 0; i--) begin
            copi = val[i];
            #HALF sclk = 1'b1;
            cap = {cap[14:0], cipo};
            #HALF sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [31:0] val, input int n, output logic [15:0] cap);
        @(negedge clk);
        ncs = 1'b0;
        #HALF;
        spi_bits(val, n, cap);
        #HALF ncs = 1'b1;
    endtask

    task automatic settle();
        repeat (30) @(posedge clk);
        #10;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        repeat (3) @(posedge clk);
        #10;
        checks++;
        if (regs_all !== {32'h0, RDUTY}) begin
            errors++; $display("FAIL reset_regs: got %h want %h", regs_all, {32'h0, RDUTY});
        end
        checks++;
        if ({cipo, txn_done, txn_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {cipo, txn_done, txn_err});
        end
        rst_n = 1'b1;
        settle();
    endtask

    task automatic test_write();
        logic [15:0] cap;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(32'h80A5, 16, cap);
        repeat (3) @(posedge clk);
        #10;
        checks++;
        if (en_reg_out_7_0 !== 8'h00 || txn_done !== 1'b0) begin
            errors++; $display("FAIL write_early: reg %h done %b want 00 0", en_reg_out_7_0, txn_done);
        end
        @(posedge clk);
        #10;
        checks++;
        if (en_reg_out_7_0 !== 8'hA5 || txn_done !== 1'b1) begin
            errors++; $display("FAIL write_latency: reg %h done %b want a5 1", en_reg_out_7_0, txn_done);
        end
        settle();
        checks++;
        if (regs_all !== {8'hA5, 24'h0, RDUTY}) begin
            errors++; $display("FAIL write_regs: got %h want %h", regs_all, {8'hA5, 24'h0, RDUTY});
        end
        checks++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            errors++; $display("FAIL write_pulses: done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] cap;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(32'h8480, 16, cap);
        settle();
        spi_frame(32'h82FF, 16, cap);
        settle();
        checks++;
        if (regs_all !== {8'hA5, 8'h00, 8'hFF, 8'h00, 8'h80}) begin
            errors++; $display("FAIL b2b_regs: got %h want a500ff0080", regs_all);
        end
        checks++;
        if (done_cnt - d0 !== 2 || err_cnt - e0 !== 0) begin
            errors++; $display("FAIL b2b_pulses: done %0d err %0d want 2 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_bad_length();
        logic [15:0] cap;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(32'h4052, 15, cap);
        settle();
        checks++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
            errors++; $display("FAIL short_pulses: err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0);
        end
        spi_frame(32'h1_80_11, 17, cap);
        settle();
        checks++;
        if (err_cnt - e0 !== 2 || done_cnt - d0 !== 0) begin
            errors++; $display("FAIL long_pulses: err %0d done %0d want 2 0", err_cnt - e0, done_cnt - d0);
        end
        checks++;
        if (regs_all !== {8'hA5, 8'h00, 8'hFF, 8'h00, 8'h80}) begin
            errors++; $display("FAIL badlen_regs: got %h want a500ff0080", regs_all);
        end
    endtask

    task automatic test_bad_addr();
        logic [15:0] cap;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(32'h85FF, 16, cap);
        settle();
        checks++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
            errors++; $display("FAIL badaddr_pulses: err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0);
        end
        checks++;
        if (regs_all !== {8'hA5, 8'h00, 8'hFF, 8'h00, 8'h80}) begin
            errors++; $display("FAIL badaddr_regs: got %h want a500ff0080", regs_all);
        end
    endtask

    task automatic test_readback();
        logic [15:0] cap;
        int d0, e0, dexp;
        spi_frame(32'h823C, 16, cap);
        settle();
        checks++;
        if (en_reg_pwm_7_0 !== 8'h3C) begin
            errors++; $display("FAIL rb_write: got %h want 3c", en_reg_pwm_7_0);
        end
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(32'h0200, 16, cap);
        settle();
`ifdef SPI_READBACK_EN
        dexp = 1;
        checks++;
        if (cap !== 16'h003C) begin
            errors++; $display("FAIL rb_cipo: got %h want 003c", cap);
        end
`else
        dexp = 0;
        checks++;
        if (cap !== 16'h0000) begin
            errors++; $display("FAIL rb_cipo: got %h want 0000", cap);
        end
`endif
        checks++;
        if (done_cnt - d0 !== dexp || err_cnt - e0 !== 0) begin
            errors++; $display("FAIL rb_pulses: done %0d err %0d want %0d 0", done_cnt - d0, err_cnt - e0, dexp);
        end
        checks++;
        if (cipo !== 1'b0 || regs_all !== {8'hA5, 8'h00, 8'h3C, 8'h00, 8'h80}) begin
            errors++; $display("FAIL rb_after: cipo %b regs %h want 0 a5003c0080", cipo, regs_all);
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] cap;
        int d0, e0;
        @(negedge clk);
        ncs = 1'b0;
        #HALF;
        spi_bits(32'h81, 8, cap);
        #(HALF/2) rst_n = 1'b0;
        #200;
        checks++;
        if (regs_all !== {32'h0, RDUTY} || {cipo, txn_done, txn_err} !== 3'b000) begin
            errors++; $display("FAIL midrst_outputs: regs %h flags %b want %h 000",
                               regs_all, {cipo, txn_done, txn_err}, {32'h0, RDUTY});
        end
        rst_n = 1'b1;
        #(HALF/2 - 200);
        d0 = done_cnt; e0 = err_cnt;
        spi_bits(32'hAA, 8, cap);
        #HALF ncs = 1'b1;
        settle();
        checks++;
        if (regs_all !== {32'h0, RDUTY} || done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            errors++; $display("FAIL midrst_tail: regs %h done %0d err %0d want %h 0 0",
                               regs_all, done_cnt - d0, err_cnt - e0, {32'h0, RDUTY});
        end
        spi_frame(32'h8133, 16, cap);
        settle();
        checks++;
        if (regs_all !== {8'h00, 8'h33, 16'h0, RDUTY} || done_cnt - d0 !== 1) begin
            errors++; $display("FAIL midrst_next: regs %h done %0d want %h 1",
                               regs_all, done_cnt - d0, {8'h00, 8'h33, 16'h0, RDUTY});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_bad_length();
        test_bad_addr();
        test_readback();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
